// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: output-stationary N x N systolic matrix multiplier.
// It streams K columns of A and K rows of B from synchronous memories through
// a skewed PE grid, then writes C back one packed row per cycle.
// Optional build macro SYSTOLIC_SATURATE_EN: the accumulators clamp to the
// signed ACC_W range instead of wrapping.
module systolic_matmul_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 8,
  parameter int KW     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [KW-1:0]         k_len,
  input  logic [ADDR_W-1:0]     base_address_A,
  input  logic [ADDR_W-1:0]     base_address_B,
  input  logic [ADDR_W-1:0]     base_address_C,
  output logic [ADDR_W-1:0]     a_addr,
  input  logic [N*DATA_W-1:0]   a_rdata,
  output logic [ADDR_W-1:0]     b_addr,
  input  logic [N*DATA_W-1:0]   b_rdata,
  output logic                  c_we,
  output logic [ADDR_W-1:0]     c_addr,
  output logic [N*ACC_W-1:0]    c_wdata,
  output logic                  busy,
  output logic                  complete
);

  // The counter has to cover both the K stream cycles and the 2N flush cycles.
  localparam int CNT_W = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  k_last;
  logic [KW-1:0]     k_reg;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic              valid;

  logic signed [DATA_W-1:0] a_lane [N];
  logic signed [DATA_W-1:0] b_lane [N];
  logic signed [DATA_W-1:0] a_sk   [N];
  logic signed [DATA_W-1:0] b_sk   [N];
  logic signed [DATA_W-1:0] a_dly  [N][N-1];
  logic signed [DATA_W-1:0] b_dly  [N][N-1];
  logic signed [DATA_W-1:0] a_pe   [N][N];
  logic signed [DATA_W-1:0] b_pe   [N][N];
  logic signed [DATA_W-1:0] a_reg  [N][N-1];
  logic signed [DATA_W-1:0] b_reg  [N-1][N];
  logic signed [ACC_W-1:0]  acc    [N][N];

  assign k_last = CNT_W'(k_reg) - CNT_W'(1);

  // One multiply-accumulate step; the product is sign-extended before the add.
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  acc_in,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
`ifdef SYSTOLIC_SATURATE_EN
    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0]      sum;
`endif
    prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_ext = ACC_W'(prod);
`ifdef SYSTOLIC_SATURATE_EN
    sum = (ACC_W+1)'(acc_in) + (ACC_W+1)'(prod_ext);
    if (sum > ACC_MAX) begin
      return ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      return ACC_MIN[ACC_W-1:0];
    end
    return sum[ACC_W-1:0];
`else
    return acc_in + prod_ext;
`endif
  endfunction

  // Lane unpacking, input skew taps and PE operand wiring.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign a_lane[i] = valid ? a_rdata[i*DATA_W +: DATA_W] : '0;
    assign b_lane[i] = valid ? b_rdata[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_nodly
      assign a_sk[i] = a_lane[i];
      assign b_sk[i] = b_lane[i];
    end else begin : g_dly
      assign a_sk[i] = a_dly[i][i-1];
      assign b_sk[i] = b_dly[i][i-1];
    end
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_pe[i][j] = a_sk[i];
      end else begin : g_a_inner
        assign a_pe[i][j] = a_reg[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_pe[i][j] = b_sk[j];
      end else begin : g_b_inner
        assign b_pe[i][j] = b_reg[i-1][j];
      end
    end
  end

  // State register, phase counter, latched job parameters and read-data valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k_reg  <= '0;
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      valid  <= 1'b0;
    end else begin
      state <= state_next;
      valid <= (state == S_STREAM);
      if (state_next != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == S_IDLE || state == S_DONE) && init) begin
        k_reg  <= k_len;
        base_a <= base_address_A;
        base_b <= base_address_B;
        base_c <= base_address_C;
      end
    end
  end

  // Next-state decode and all outputs, which depend only on state and counter.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    complete   = 1'b0;
    c_we       = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    c_addr     = '0;
    c_wdata    = '0;
    unique case (state)
      S_IDLE: begin
        if (init) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        busy       = 1'b1;
        state_next = (k_reg == '0) ? S_FLUSH : S_STREAM;
      end
      S_STREAM: begin
        busy   = 1'b1;
        a_addr = base_a + ADDR_W'(cnt);
        b_addr = base_b + ADDR_W'(cnt);
        if (cnt == k_last) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (cnt == FLUSH_LAST) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        c_we   = 1'b1;
        c_addr = base_c + ADDR_W'(cnt);
        for (int r = 0; r < N; r++) begin
          if (cnt == CNT_W'(r)) begin
            for (int j = 0; j < N; j++) begin
              c_wdata[j*ACC_W +: ACC_W] = acc[r][j];
            end
          end
        end
        if (cnt == DRAIN_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        complete = 1'b1;
        if (init) state_next = S_CLEAR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Skew lines, PE operand pipelines and accumulators; they only move while operands flow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N - 1; d++) begin
          a_dly[i][d] <= '0;
          b_dly[i][d] <= '0;
          a_reg[i][d] <= '0;
        end
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_reg[i][j] <= '0;
      end
    end else if (state == S_CLEAR) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N - 1; d++) begin
          a_dly[i][d] <= '0;
          b_dly[i][d] <= '0;
          a_reg[i][d] <= '0;
        end
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_reg[i][j] <= '0;
      end
    end else if (state == S_STREAM || state == S_FLUSH) begin
      for (int i = 0; i < N; i++) begin
        a_dly[i][0] <= a_lane[i];
        b_dly[i][0] <= b_lane[i];
        for (int d = 1; d < N - 1; d++) begin
          a_dly[i][d] <= a_dly[i][d-1];
          b_dly[i][d] <= b_dly[i][d-1];
        end
        for (int j = 0; j < N - 1; j++) a_reg[i][j] <= a_pe[i][j];
        for (int j = 0; j < N; j++) acc[i][j] <= mac(acc[i][j], a_pe[i][j], b_pe[i][j]);
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_reg[i][j] <= b_pe[i][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb_systolic_matmul_engine: drives the matmul engine from small behavioural
// memories and compares every written C row against a sum-of-products model.
module tb_systolic_matmul_engine;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int ADDR_W = 8;
  localparam int KW     = 8;

  logic                clk;
  logic                rst;
  logic                init;
  logic [KW-1:0]       k_len;
  logic [ADDR_W-1:0]   base_address_A;
  logic [ADDR_W-1:0]   base_address_B;
  logic [ADDR_W-1:0]   base_address_C;
  logic [ADDR_W-1:0]   a_addr;
  logic [N*DATA_W-1:0] a_rdata;
  logic [ADDR_W-1:0]   b_addr;
  logic [N*DATA_W-1:0] b_rdata;
  logic                c_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [N*ACC_W-1:0]  c_wdata;
  logic                busy;
  logic                complete;

  logic [N*DATA_W-1:0] mem_a [256];
  logic [N*DATA_W-1:0] mem_b [256];
  logic [N*ACC_W-1:0]  mem_c [256];

  int checks = 0;
  int errors = 0;

  systolic_matmul_engine #(
    .N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .k_len(k_len),
    .base_address_A(base_address_A), .base_address_B(base_address_B),
    .base_address_C(base_address_C),
    .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .busy(busy), .complete(complete)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read A/B memories and the C result memory.
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
    if (c_we) mem_c[c_addr] <= c_wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int elem_a(input logic [7:0] addr, input int lane);
    logic signed [DATA_W-1:0] v;
    v = mem_a[addr][lane*DATA_W +: DATA_W];
    return int'(v);
  endfunction

  function automatic int elem_b(input logic [7:0] addr, input int lane);
    logic signed [DATA_W-1:0] v;
    v = mem_b[addr][lane*DATA_W +: DATA_W];
    return int'(v);
  endfunction

  // Bring a running sum back into the accumulator's representable range.
  function automatic int limit_acc(input int v);
    logic signed [ACC_W-1:0] t;
`ifdef SYSTOLIC_SATURATE_EN
    if (v > (1 << (ACC_W - 1)) - 1) return (1 << (ACC_W - 1)) - 1;
    if (v < -(1 << (ACC_W - 1))) return -(1 << (ACC_W - 1));
    return v;
`else
    t = ACC_W'(v);
    return int'(t);
`endif
  endfunction

  // Row i of C = sum over k of A[i][k] * B[k][j], accumulated in k order.
  function automatic logic [N*ACC_W-1:0] model_row(input logic [7:0] ba, input logic [7:0] bb,
                                                   input int k, input int i);
    logic [N*ACC_W-1:0] row;
    int sum;
    row = '0;
    for (int j = 0; j < N; j++) begin
      sum = 0;
      for (int kk = 0; kk < k; kk++) begin
        sum = limit_acc(sum + elem_a(ba + 8'(kk), i) * elem_b(bb + 8'(kk), j));
      end
      row[j*ACC_W +: ACC_W] = ACC_W'(sum);
    end
    return row;
  endfunction

  // Launch one job, check the cycle-by-cycle schedule, then check the C rows.
  // abort_n >= 0 asserts reset in that cycle instead of finishing the job.
  task automatic applyStimulus(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc,
                               input int k, input bit mid_init, input int abort_n);
    int last;
    logic [26:0] obs;
    logic [26:0] expv;
    logic e_we;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [7:0] e_c;
    for (int i = 0; i < N; i++) mem_c[bc + 8'(i)] = {$urandom, $urandom};
    base_address_A = ba;
    base_address_B = bb;
    base_address_C = bc;
    k_len = KW'(k);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    base_address_A = 8'($urandom);
    base_address_B = 8'($urandom);
    base_address_C = 8'($urandom);
    k_len = KW'($urandom);
    last = k + 3 * N + 1;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == abort_n) begin
        rst = 1'b0;
        #1;
        checkOutput("abort_ctl", 64'({busy, complete, c_we, a_addr, b_addr, c_addr}), 64'd0);
        return;
      end
      e_we = (n >= k + 2 * N + 1) && (n <= k + 3 * N);
      e_a  = (n >= 1 && n <= k) ? ba + 8'(n - 1) : 8'd0;
      e_b  = (n >= 1 && n <= k) ? bb + 8'(n - 1) : 8'd0;
      e_c  = e_we ? bc + 8'(n - k - 2 * N - 1) : 8'd0;
      expv = {(n < last), (n == last), e_we, e_a, e_b, e_c};
      obs  = {busy, complete, c_we, a_addr, b_addr, c_addr};
      checkOutput("sched", 64'(obs), 64'(expv));
      if (mid_init) begin
        if (n == 2) init = 1'b1;
        else if (n == 3) init = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      checkOutput("c_row", 64'(mem_c[bc + 8'(i)]), 64'(model_row(ba, bb, k, i)));
    end
  endtask

  initial begin
    logic [63:0] ovf_row;
    rst = 1'b0;
    init = 1'b0;
    k_len = '0;
    base_address_A = '0;
    base_address_B = '0;
    base_address_C = '0;
    for (int a = 0; a < 256; a++) begin
      mem_a[a] = '0;
      mem_b[a] = '0;
      mem_c[a] = '0;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctl", 64'({busy, complete, c_we, a_addr, b_addr, c_addr}), 64'd0);
    checkOutput("reset_wdata", 64'(c_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_ctl", 64'({busy, complete, c_we, a_addr, b_addr, c_addr}), 64'd0);

    // Identity A, B[k][j] = 4k + j.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        mem_a[k][i*DATA_W +: DATA_W] = (i == k) ? 8'd1 : 8'd0;
        mem_b[k][i*DATA_W +: DATA_W] = 8'(4 * k + i);
      end
    end
    applyStimulus(8'h00, 8'h00, 8'h00, 4, 1'b0, -1);
    checkOutput("ident_row1", 64'(mem_c[1]), {16'd7, 16'd6, 16'd5, 16'd4});

    // Outer product, K = 1.
    mem_a[8'h20] = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
    mem_b[8'h30] = {8'sd2, -8'sd7, 8'sd5, -8'sd1};
    applyStimulus(8'h20, 8'h30, 8'h40, 1, 1'b0, -1);
    checkOutput("outer_c32", 64'(mem_c[8'h43][2*ACC_W +: ACC_W]), 64'(16'hFFE4));

    // Address wrap on A and C.
    for (int k = 0; k < 4; k++) begin
      mem_a[8'hFE + 8'(k)] = $urandom;
      mem_b[8'h80 + 8'(k)] = $urandom;
    end
    applyStimulus(8'hFE, 8'h80, 8'hFE, 4, 1'b0, -1);

    // Overflow: all operands -128, K = 4 gives 65536 before range limiting.
    for (int k = 0; k < 4; k++) begin
      mem_a[8'h50 + 8'(k)] = {N{8'h80}};
      mem_b[8'h60 + 8'(k)] = {N{8'h80}};
    end
    applyStimulus(8'h50, 8'h60, 8'h70, 4, 1'b0, -1);
`ifdef SYSTOLIC_SATURATE_EN
    ovf_row = {N{16'h7FFF}};
`else
    ovf_row = 64'd0;
`endif
    checkOutput("ovf_row0", 64'(mem_c[8'h70]), ovf_row);

    // Fill all operand memory with random data for the remaining runs.
    for (int a = 0; a < 256; a++) begin
      mem_a[a] = $urandom;
      mem_b[a] = $urandom;
    end

    // init pulsed during STREAM is ignored.
    applyStimulus(8'h10, 8'h90, 8'h20, 5, 1'b1, -1);

    // K = 0 writes zero rows.
    applyStimulus(8'h33, 8'h44, 8'h55, 0, 1'b0, -1);

    // Random back-to-back runs.
    repeat (8) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 12), 1'b0, -1);
    end

    // Reset during DRAIN after rows 0 and 1, then a clean run.
    applyStimulus(8'h05, 8'h06, 8'hA0, 3, 1'b0, 3 + 2 * N + 1 + 2);
    @(posedge clk);
    #1;
    checkOutput("abort_hold", 64'({busy, complete, c_we}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_abort_idle", 64'({busy, complete, c_we, a_addr, b_addr, c_addr}), 64'd0);
    applyStimulus(8'h05, 8'h06, 8'hA0, 3, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
